imem_boot_loader: RTL

- Sequences program loading into the instruction memory of design_1_wrapper over its byte-wide cmd/cmd_valid/address/data_in/cmd_done port.
- Accepts 32-bit RISC-V instruction words on a valid/ready stream and splits each word into four byte writes, most-significant byte at the lowest address.
- After the last word is written, raises start_signal so the core begins execution.
- Replaces the hand-written byte-by-byte load sequence used in bring-up.

---
 rtl/imem_boot_loader.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Streams 32-bit instruction words into a byte-wide instruction-memory command
// port. Each word is written most-significant byte first. After the last word,
// start_signal is raised so the core begins execution.
// Optional read-back verification of every written byte is enabled by defining
// the macro IMEM_LOADER_VERIFY_EN.
module imem_boot_loader #(
    parameter logic [7:0] CMD_WRITE  = 8'd2,
    parameter logic [7:0] CMD_READ   = 8'd1,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_req,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    input  logic        word_last,
    output logic        word_ready,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic [7:0]  address,
    output logic [7:0]  data_in,
    input  logic        cmd_done,
    input  logic [7:0]  data_out,
    output logic        start_signal,
    output logic        busy,
    output logic        err
);

`ifdef IMEM_LOADER_VERIFY_EN
    typedef enum logic [3:0] {
        IDLE, ACCEPT, ISSUE, WAIT_DONE, GAP, RUN, ERROR, RD_ISSUE, RD_WAIT, RD_GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, ACCEPT, ISSUE, WAIT_DONE, GAP, RUN, ERROR
    } state_t;
`endif

    // One counter serves both the GAP spacing and the cmd_done timeout.
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_n;
    logic [8:0]       ptr, ptr_n;        // bit 8 set means all 256 bytes used
    logic [1:0]       idx, idx_n;
    logic             last_q, last_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      word_q;
    logic [7:0]       cmd_n;
    logic             cmd_valid_n;
    logic [7:0]       address_n;
    logic [7:0]       data_in_n;
    logic             advance;
    logic             accept;

    // Byte i of a word, byte 0 being the most significant.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_sel = w[31:24];
            2'd1:    byte_sel = w[23:16];
            2'd2:    byte_sel = w[15:8];
            default: byte_sel = w[7:0];
        endcase
    endfunction

    assign accept       = (state == ACCEPT) && word_valid;
    assign word_ready   = (state == ACCEPT);
    assign start_signal = (state == RUN);
    assign err          = (state == ERROR);
    assign busy         = (state != IDLE) && (state != RUN);

`ifndef IMEM_LOADER_VERIFY_EN
    // Read-back path is absent in this build.
    logic unused_rd;
    assign unused_rd = ^{data_out, CMD_READ};
`endif

    // Next-state, pointer, counter and command-port values.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        idx_n       = idx;
        last_n      = last_q;
        cnt_n       = cnt;
        cmd_n       = cmd;
        cmd_valid_n = cmd_valid;
        address_n   = address;
        data_in_n   = data_in;
        advance     = 1'b0;

        case (state)
            IDLE: ;
            ACCEPT: begin
                if (word_valid) begin
                    last_n = word_last;
                    idx_n  = 2'd0;
                    if (ptr[8]) begin
                        state_n = ERROR;
                    end else begin
                        state_n     = ISSUE;
                        cmd_n       = CMD_WRITE;
                        cmd_valid_n = 1'b1;
                        address_n   = ptr[7:0];
                        data_in_n   = word_data[31:24];
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT_DONE;
                cnt_n   = '0;
            end
            WAIT_DONE: begin
                if (cmd_done) begin
                    cmd_n       = '0;
                    cmd_valid_n = 1'b0;
                    address_n   = '0;
                    data_in_n   = '0;
                    ptr_n       = ptr + 9'd1;
                    cnt_n       = '0;
                    state_n     = GAP;
                end else if (cnt == TO_LAST) begin
                    cmd_n       = '0;
                    cmd_valid_n = 1'b0;
                    address_n   = '0;
                    data_in_n   = '0;
                    state_n     = ERROR;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
`ifdef IMEM_LOADER_VERIFY_EN
                    // Read back the byte just written; ptr already points past it.
                    state_n     = RD_ISSUE;
                    cmd_n       = CMD_READ;
                    cmd_valid_n = 1'b1;
                    address_n   = ptr[7:0] - 8'd1;
                    data_in_n   = '0;
`else
                    advance = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef IMEM_LOADER_VERIFY_EN
            RD_ISSUE: begin
                state_n = RD_WAIT;
                cnt_n   = '0;
            end
            RD_WAIT: begin
                if (cmd_done || (cnt == TO_LAST)) begin
                    cmd_n       = '0;
                    cmd_valid_n = 1'b0;
                    address_n   = '0;
                    cnt_n       = '0;
                    if (cmd_done && (data_out == byte_sel(word_q, idx)))
                        state_n = RD_GAP;
                    else
                        state_n = ERROR;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RD_GAP: begin
                if (cnt == GAP_LAST)
                    advance = 1'b1;
                else
                    cnt_n = cnt + CNT_W'(1);
            end
`endif
            RUN: ;
            ERROR: ;
            default: state_n = IDLE;
        endcase

        // End of a byte's spacing: next byte of this word, next word, or run.
        if (advance) begin
            cnt_n = '0;
            if (idx != 2'd3) begin
                if (ptr[8]) begin
                    state_n = ERROR;
                end else begin
                    idx_n       = idx + 2'd1;
                    state_n     = ISSUE;
                    cmd_n       = CMD_WRITE;
                    cmd_valid_n = 1'b1;
                    address_n   = ptr[7:0];
                    data_in_n   = byte_sel(word_q, idx + 2'd1);
                end
            end else if (last_q) begin
                state_n = RUN;
            end else begin
                state_n = ACCEPT;
            end
        end

        // load_req restarts from address 0 out of any state, aborting a command.
        if (load_req) begin
            state_n     = ACCEPT;
            ptr_n       = '0;
            cnt_n       = '0;
            cmd_n       = '0;
            cmd_valid_n = 1'b0;
            address_n   = '0;
            data_in_n   = '0;
        end
    end

    // Control state and the registered command port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            last_q    <= 1'b0;
            cnt       <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            address   <= '0;
            data_in   <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            idx       <= idx_n;
            last_q    <= last_n;
            cnt       <= cnt_n;
            cmd       <= cmd_n;
            cmd_valid <= cmd_valid_n;
            address   <= address_n;
            data_in   <= data_in_n;
        end
    end

    // Word holding register; only meaningful after a word is accepted.
    always_ff @(posedge clk) begin
        if (accept)
            word_q <= word_data;
    end

endmodule
